// File: rtl/hazard_pkg.sv
// Shared types and widths for the decode hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned FLUSH_CNT_W  = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    FLUSHING = 1'b1
  } flush_state_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter of outstanding writes for one architectural register.
//   CLK, RESET   : clock, synchronous active-high reset
//   inc_i        : a writer to this register issued this cycle
//   dec_i        : writeback to this register this cycle (may arrive with count 0)
//   cnt_o        : current outstanding-write count
//   underflow_o  : dec_i while count is 0 (count stays at 0)
module pend_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero, max, dec_eff;

  assign zero        = (cnt_q == '0);
  assign max         = (cnt_q == '1);
  assign dec_eff     = dec_i & ~zero;
  assign underflow_o = dec_i & zero;
  assign cnt_o       = cnt_q;

  // Simultaneous issue and retire of the same register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && dec_eff) begin
      cnt_d = cnt_q;
    end else if (inc_i && !max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_eff) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: tracks outstanding register writes, stalls decode on
// RAW/WAW-saturation hazards and sequences the post-branch flush.
// Optional feature: define HAZARD_WB_BYPASS_EN to treat a source whose last pending write
// retires this cycle as forwarded (no stall).
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   ID_VALID                    decode holds a valid instruction
//   ID_RS1/ID_RS2, ID_USES_RS1/2 source indices and read enables
//   ID_RD, ID_WRITES_RD         destination index and write enable
//   WB_VALID, WB_RD             writeback retiring a write
//   BRANCH_TAKEN                one-cycle taken-branch pulse
//   STALL                       decode hold (combinational)
//   FLUSH                       squash IF/ID and ID/EX
//   PC_WRITE_EN, IF_ID_WRITE_EN pipeline front-end enables
//   ISSUE                       instruction leaves decode this cycle
//   BUSY_MASK                   registers with outstanding writes
//   ERR                         sticky writeback-without-pending-write flag
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG         = NREG_DEFAULT,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_WRITES_RD,
  input  logic                  WB_VALID,
  input  logic [REG_ADDR_W-1:0] WB_RD,
  input  logic                  BRANCH_TAKEN,
  output logic                  STALL,
  output logic                  FLUSH,
  output logic                  PC_WRITE_EN,
  output logic                  IF_ID_WRITE_EN,
  output logic                  ISSUE,
  output logic [NREG-1:0]       BUSY_MASK,
  output logic                  ERR
);

  logic [NREG-1:0][CNT_W-1:0] pend;
  logic [NREG-1:0]            underflow;

  flush_state_t               state_q, state_d;
  logic [FLUSH_CNT_W-1:0]     fcnt_q, fcnt_d;
  logic                       err_q;

  logic hazard1, hazard2, waw_sat;

  // x0 is never tracked.
  assign pend[0]      = '0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK         (CLK),
      .RESET       (RESET),
      .inc_i       (ISSUE & ID_WRITES_RD & (ID_RD == REG_ADDR_W'(r))),
      .dec_i       (WB_VALID & (WB_RD == REG_ADDR_W'(r))),
      .cnt_o       (pend[r]),
      .underflow_o (underflow[r])
    );
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign BUSY_MASK[r] = (pend[r] != '0);
  end

  // Source hazard: read of a register with outstanding writes.
`ifdef HAZARD_WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1    = WB_VALID & (WB_RD == ID_RS1) & (pend[ID_RS1] == CNT_W'(1));
  assign byp2    = WB_VALID & (WB_RD == ID_RS2) & (pend[ID_RS2] == CNT_W'(1));
  assign hazard1 = ID_USES_RS1 & (ID_RS1 != '0) & (pend[ID_RS1] != '0) & ~byp1;
  assign hazard2 = ID_USES_RS2 & (ID_RS2 != '0) & (pend[ID_RS2] != '0) & ~byp2;
`else
  assign hazard1 = ID_USES_RS1 & (ID_RS1 != '0) & (pend[ID_RS1] != '0);
  assign hazard2 = ID_USES_RS2 & (ID_RS2 != '0) & (pend[ID_RS2] != '0);
`endif

  // Another writer would overflow the destination's counter.
  assign waw_sat = ID_WRITES_RD & (ID_RD != '0) & (pend[ID_RD] == '1);

  assign STALL          = ID_VALID & (hazard1 | hazard2 | waw_sat);
  assign FLUSH          = (state_q == FLUSHING);
  assign PC_WRITE_EN    = ~STALL | FLUSH;
  assign IF_ID_WRITE_EN = ~STALL | FLUSH;
  assign ISSUE          = ID_VALID & ~STALL & ~FLUSH;
  assign ERR            = err_q;

  // Flush sequencer: a taken branch (re)loads the remaining-cycle count.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (BRANCH_TAKEN) begin
          state_d = FLUSHING;
          fcnt_d  = FLUSH_CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSHING: begin
        if (BRANCH_TAKEN) begin
          fcnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
        end else if (fcnt_q == FLUSH_CNT_W'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_q | (|underflow);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        CLK, RESET;
  logic        ID_VALID, ID_USES_RS1, ID_USES_RS2, ID_WRITES_RD;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD, WB_RD;
  logic        WB_VALID, BRANCH_TAKEN;
  logic        STALL, FLUSH, PC_WRITE_EN, IF_ID_WRITE_EN, ISSUE, ERR;
  logic [31:0] BUSY_MASK;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .CLK(CLK), .RESET(RESET),
    .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .ID_RD(ID_RD), .ID_WRITES_RD(ID_WRITES_RD),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .BRANCH_TAKEN(BRANCH_TAKEN),
    .STALL(STALL), .FLUSH(FLUSH), .PC_WRITE_EN(PC_WRITE_EN),
    .IF_ID_WRITE_EN(IF_ID_WRITE_EN), .ISSUE(ISSUE),
    .BUSY_MASK(BUSY_MASK), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ID_VALID = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0; ID_WRITES_RD = 0;
    ID_RS1 = 0; ID_RS2 = 0; ID_RD = 0;
    WB_VALID = 0; WB_RD = 0; BRANCH_TAKEN = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1;
    tick(); tick();
    RESET = 0;
    ID_VALID = 1; ID_USES_RS1 = 1; ID_RS1 = 5'd1;
    #1;
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", STALL); end
    total++; if (FLUSH !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", FLUSH); end
    total++; if (BUSY_MASK !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", BUSY_MASK); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", ERR); end
    total++; if (PC_WRITE_EN !== 1'b1 || IF_ID_WRITE_EN !== 1'b1) begin bad++; $display("FAIL reset_en got=%b%b want=11", PC_WRITE_EN, IF_ID_WRITE_EN); end
    clear_inputs();
    #1;
  endtask

  task automatic test_raw();
    clear_inputs();
    ID_VALID = 1; ID_WRITES_RD = 1; ID_RD = 5'd5;
    #1;
    total++; if (ISSUE !== 1'b1) begin bad++; $display("FAIL raw_issue_writer got=%b want=1", ISSUE); end
    tick();
    clear_inputs();
    ID_VALID = 1; ID_USES_RS1 = 1; ID_RS1 = 5'd5;
    #1;
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b want=1", STALL); end
    total++; if (BUSY_MASK !== 32'h0000_0020) begin bad++; $display("FAIL raw_busy got=%h want=00000020", BUSY_MASK); end
    total++; if (PC_WRITE_EN !== 1'b0 || ISSUE !== 1'b0) begin bad++; $display("FAIL raw_hold got=%b%b want=00", PC_WRITE_EN, ISSUE); end
    tick();
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL raw_stall_held got=%b want=1", STALL); end
    WB_VALID = 1; WB_RD = 5'd5;
    #1;
`ifdef HAZARD_WB_BYPASS_EN
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL raw_wb_cycle got=%b want=0", STALL); end
`else
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL raw_wb_cycle got=%b want=1", STALL); end
`endif
    tick();
    WB_VALID = 0;
    #1;
    total++; if (STALL !== 1'b0 || ISSUE !== 1'b1) begin bad++; $display("FAIL raw_release got=%b%b want=01", STALL, ISSUE); end
    total++; if (BUSY_MASK !== 32'h0) begin bad++; $display("FAIL raw_busy_clear got=%h want=0", BUSY_MASK); end
    clear_inputs();
    tick();
  endtask

  task automatic test_waw_sat();
    clear_inputs();
    ID_VALID = 1; ID_WRITES_RD = 1; ID_RD = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ISSUE !== 1'b1) begin bad++; $display("FAIL waw_issue%0d got=%b want=1", i, ISSUE); end
      tick();
    end
    #1;
    total++; if (STALL !== 1'b1 || ISSUE !== 1'b0) begin bad++; $display("FAIL waw_sat got=%b%b want=10", STALL, ISSUE); end
    total++; if (BUSY_MASK !== 32'h0000_0080) begin bad++; $display("FAIL waw_busy got=%h want=00000080", BUSY_MASK); end
    WB_VALID = 1; WB_RD = 5'd7;
    #1;
    total++; if (STALL !== 1'b1) begin bad++; $display("FAIL waw_wb_cycle got=%b want=1", STALL); end
    tick();
    WB_VALID = 0;
    #1;
    total++; if (STALL !== 1'b0 || ISSUE !== 1'b1) begin bad++; $display("FAIL waw_fourth got=%b%b want=01", STALL, ISSUE); end
    tick();
    // Back at 3 after the fourth issue: three retirements must drain it exactly.
    clear_inputs();
    WB_VALID = 1; WB_RD = 5'd7;
    tick(); tick();
    #1;
    total++; if (BUSY_MASK !== 32'h0000_0080) begin bad++; $display("FAIL waw_drain2 got=%h want=00000080", BUSY_MASK); end
    tick();
    WB_VALID = 0;
    #1;
    total++; if (BUSY_MASK !== 32'h0 || ERR !== 1'b0) begin bad++; $display("FAIL waw_drained got=%h/%b want=0/0", BUSY_MASK, ERR); end
  endtask

  task automatic test_same_edge();
    clear_inputs();
    ID_VALID = 1; ID_WRITES_RD = 1; ID_RD = 5'd9;
    tick();
    WB_VALID = 1; WB_RD = 5'd9;
    #1;
    total++; if (ISSUE !== 1'b1) begin bad++; $display("FAIL same_issue got=%b want=1", ISSUE); end
    tick();
    clear_inputs();
    #1;
    total++; if (BUSY_MASK !== 32'h0000_0200) begin bad++; $display("FAIL same_busy got=%h want=00000200", BUSY_MASK); end
    WB_VALID = 1; WB_RD = 5'd9;
    tick();
    WB_VALID = 0;
    #1;
    total++; if (BUSY_MASK !== 32'h0 || ERR !== 1'b0) begin bad++; $display("FAIL same_drain got=%h/%b want=0/0", BUSY_MASK, ERR); end
  endtask

  task automatic test_flush();
    clear_inputs();
    BRANCH_TAKEN = 1;
    #1;
    total++; if (FLUSH !== 1'b0) begin bad++; $display("FAIL flush_t got=%b want=0", FLUSH); end
    tick();
    BRANCH_TAKEN = 0;
    ID_VALID = 1; ID_WRITES_RD = 1; ID_RD = 5'd10;
    #1;
    total++; if (FLUSH !== 1'b1 || ISSUE !== 1'b0) begin bad++; $display("FAIL flush_t1 got=%b%b want=10", FLUSH, ISSUE); end
    total++; if (PC_WRITE_EN !== 1'b1 || IF_ID_WRITE_EN !== 1'b1) begin bad++; $display("FAIL flush_en got=%b%b want=11", PC_WRITE_EN, IF_ID_WRITE_EN); end
    tick();
    total++; if (FLUSH !== 1'b1 || ISSUE !== 1'b0) begin bad++; $display("FAIL flush_t2 got=%b%b want=10", FLUSH, ISSUE); end
    tick();
    ID_VALID = 0;
    #1;
    total++; if (FLUSH !== 1'b0) begin bad++; $display("FAIL flush_t3 got=%b want=0", FLUSH); end
    total++; if (BUSY_MASK !== 32'h0) begin bad++; $display("FAIL flush_squash got=%h want=0", BUSY_MASK); end
    // Re-trigger while flushing extends the window.
    clear_inputs();
    BRANCH_TAKEN = 1;
    tick();
    #1;
    total++; if (FLUSH !== 1'b1) begin bad++; $display("FAIL reflush_t1 got=%b want=1", FLUSH); end
    tick();
    BRANCH_TAKEN = 0;
    #1;
    total++; if (FLUSH !== 1'b1) begin bad++; $display("FAIL reflush_t2 got=%b want=1", FLUSH); end
    tick();
    total++; if (FLUSH !== 1'b1) begin bad++; $display("FAIL reflush_t3 got=%b want=1", FLUSH); end
    tick();
    total++; if (FLUSH !== 1'b0) begin bad++; $display("FAIL reflush_t4 got=%b want=0", FLUSH); end
  endtask

  task automatic test_x0_err();
    clear_inputs();
    ID_VALID = 1; ID_WRITES_RD = 1; ID_RD = 5'd0; ID_USES_RS1 = 1; ID_RS1 = 5'd0;
    #1;
    total++; if (STALL !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b want=0", STALL); end
    tick();
    #1;
    total++; if (STALL !== 1'b0 || BUSY_MASK !== 32'h0) begin bad++; $display("FAIL x0_after got=%b/%h want=0/0", STALL, BUSY_MASK); end
    clear_inputs();
    WB_VALID = 1; WB_RD = 5'd0;
    tick();
    #1;
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL x0_wb_err got=%b want=0", ERR); end
    WB_RD = 5'd3;
    tick();
    WB_VALID = 0;
    #1;
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL underflow_err got=%b want=1", ERR); end
    total++; if (BUSY_MASK !== 32'h0) begin bad++; $display("FAIL underflow_busy got=%h want=0", BUSY_MASK); end
    tick(); tick();
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", ERR); end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    ID_VALID = 1; ID_WRITES_RD = 1; ID_RD = 5'd4;
    tick(); tick();
    clear_inputs();
    BRANCH_TAKEN = 1;
    #1;
    total++; if (BUSY_MASK !== 32'h0000_0010) begin bad++; $display("FAIL rmf_busy got=%h want=00000010", BUSY_MASK); end
    tick();
    BRANCH_TAKEN = 0;
    RESET = 1;
    #1;
    total++; if (FLUSH !== 1'b1) begin bad++; $display("FAIL rmf_flushing got=%b want=1", FLUSH); end
    tick();
    RESET = 0;
    ID_VALID = 1; ID_USES_RS1 = 1; ID_RS1 = 5'd4;
    #1;
    total++; if (FLUSH !== 1'b0 || STALL !== 1'b0) begin bad++; $display("FAIL rmf_clear got=%b%b want=00", FLUSH, STALL); end
    total++; if (BUSY_MASK !== 32'h0 || ERR !== 1'b0) begin bad++; $display("FAIL rmf_state got=%h/%b want=0/0", BUSY_MASK, ERR); end
    total++; if (ISSUE !== 1'b1) begin bad++; $display("FAIL rmf_issue got=%b want=1", ISSUE); end
    clear_inputs();
  endtask

  initial begin
    RESET = 1;
    clear_inputs();
    test_reset();
    test_raw();
    test_waw_sat();
    test_same_edge();
    test_flush();
    test_x0_err();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
